// File: rtl/acc_pkg.sv
// Shared accumulator constants, vector type and readout FSM states.
package acc_pkg;

  localparam int DIM_C        = 8;
  localparam int ACC_WIDTH    = 24;
  localparam int WEIGHT_WIDTH = 8;

  typedef logic [DIM_C-1:0][ACC_WIDTH-1:0] acc_vec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

endpackage

// File: rtl/acc_shadow_bank.sv
// DIM_C x ACC_WIDTH holding register with whole-vector load and an indexed read port.
module acc_shadow_bank #(
  parameter int DIM_C     = acc_pkg::DIM_C,
  parameter int ACC_WIDTH = acc_pkg::ACC_WIDTH,
  parameter int IDX_WIDTH = $clog2(DIM_C)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_i,
  input  logic [DIM_C-1:0][ACC_WIDTH-1:0]  data_i,
  input  logic [IDX_WIDTH-1:0]             rd_idx_i,
  output logic [ACC_WIDTH-1:0]             rd_data_o
);

  logic [DIM_C-1:0][ACC_WIDTH-1:0] bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bank_q <= '0;
    else if (load_i) bank_q <= data_i;
  end

  assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/acc_readout_serializer.sv
// Snapshots the accumulator on tile-done, clears it in the same cycle, then streams one lane per beat.
module acc_readout_serializer #(
  parameter int DIM_C     = acc_pkg::DIM_C,
  parameter int ACC_WIDTH = acc_pkg::ACC_WIDTH,
  parameter int IDX_WIDTH = $clog2(DIM_C)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [DIM_C-1:0][ACC_WIDTH-1:0]  sum_in,
  output logic                             acc_clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic [IDX_WIDTH-1:0]             out_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             overrun,
  input  logic                             err_clr
);
  import acc_pkg::*;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DIM_C - 1);

  rd_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 overrun_q, overrun_d;
  logic                 xfer, at_last, accept, reject;

  assign xfer    = (state_q == STREAM) && out_ready;
  assign at_last = (idx_q == LAST_IDX);
  // Gating with rst_n keeps a start asserted during reset from clearing the accumulator.
  assign accept  = start && rst_n && ((state_q == IDLE) || (xfer && at_last));
  assign reject  = start && (state_q == STREAM) && !accept;

  acc_shadow_bank #(
    .DIM_C     (DIM_C),
    .ACC_WIDTH (ACC_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_shadow (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .data_i    (sum_in),
    .rd_idx_i  (idx_q),
    .rd_data_o (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    // A reject in the same cycle as err_clr leaves overrun set.
    overrun_d = reject ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d   = '0;
            state_d = accept ? STREAM : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    acc_clear = accept;
    out_valid = (state_q == STREAM);
    out_last  = (state_q == STREAM) && at_last;
    busy      = (state_q == STREAM);
    out_idx   = idx_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_acc_readout_serializer.sv
// Directed bench for acc_readout_serializer: single, backpressure, back-to-back, overrun, max, reset.
module tb_acc_readout_serializer;
  localparam int DIM_C = 8;
  localparam int ACC_WIDTH = 24;
  localparam int IDX_WIDTH = 3;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic                            start;
  logic [DIM_C-1:0][ACC_WIDTH-1:0] sum_in;
  logic                            acc_clear;
  logic                            out_valid;
  logic                            out_ready;
  logic [ACC_WIDTH-1:0]            out_data;
  logic [IDX_WIDTH-1:0]            out_idx;
  logic                            out_last;
  logic                            busy;
  logic                            overrun;
  logic                            err_clr;
  logic                            acc_en;

  int checks = 0;
  int errors = 0;

  acc_readout_serializer #(.DIM_C(DIM_C), .ACC_WIDTH(ACC_WIDTH), .IDX_WIDTH(IDX_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sum_in(sum_in), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream rule: accumulate enable must never coincide with clear.
  task automatic chk_rule();
    chk("acc_en_vs_clear", {31'd0, acc_en & acc_clear}, 32'd0);
  endtask

  task automatic set_sums(input int base);
    for (int i = 0; i < DIM_C; i++) sum_in[i] = ACC_WIDTH'(base + i);
  endtask

  // Advance to just after the next rising edge; inputs are then driven and settle for #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int idx, input int data);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_idx"},   {29'd0, out_idx}, 32'(idx));
    chk({tag, "_data"},  {8'd0, out_data}, 32'(data));
    chk({tag, "_last"},  {31'd0, out_last}, {31'd0, idx == DIM_C-1});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int exp_idx;
    int cyc;
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; err_clr = 1'b0; acc_en = 1'b0;
    set_sums(100);
    #12;
    // Reset state, with start high to confirm it is ignored.
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_idx", {29'd0, out_idx}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_data", {8'd0, out_data}, 32'd0);
    chk("rst_clear", {31'd0, acc_clear}, 32'd0);
    start = 1'b0;
    tick(); rst_n = 1'b1;
    tick();

    // Single snapshot, lanes 100..107.
    start = 1'b1; #1;
    chk("single_clear", {31'd0, acc_clear}, 32'd1);
    chk("single_valid_t", {31'd0, out_valid}, 32'd0);
    chk_rule();
    tick(); start = 1'b0; set_sums(999); #1;
    chk("single_clear_off", {31'd0, acc_clear}, 32'd0);
    for (int i = 0; i < DIM_C; i++) begin
      chk_beat("single", i, 100 + i);
      chk("single_busy", {31'd0, busy}, 32'd1);
      tick(); #1;
    end
    chk_idle("single_done");

    // Backpressure: ready pattern 1,0,0 repeating.
    set_sums(200); start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    exp_idx = 0; cyc = 0;
    while (exp_idx < DIM_C && cyc < 40) begin
      out_ready = (cyc % 3 == 0); #1;
      chk_beat("bp", exp_idx, 200 + exp_idx);
      if (out_ready) exp_idx++;
      cyc++;
      tick();
    end
    chk("bp_all_beats", 32'(exp_idx), 32'(DIM_C));
    out_ready = 1'b1; #1;
    chk_idle("bp_done");

    // Back-to-back: second start on the last handshake.
    set_sums(300); start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    for (int i = 0; i < DIM_C - 1; i++) begin
      chk_beat("b2b_a", i, 300 + i);
      tick(); #1;
    end
    set_sums(400); start = 1'b1; #1;
    chk_beat("b2b_a", 7, 307);
    chk("b2b_clear", {31'd0, acc_clear}, 32'd1);
    chk_rule();
    tick(); start = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk_beat("b2b_b", i, 400 + i);
      tick(); #1;
    end

    // Overrun: start at out_idx 3 is rejected.
    start = 1'b1; #1;
    chk_beat("ovr_at3", 3, 403);
    chk("ovr_clear", {31'd0, acc_clear}, 32'd0);
    tick(); start = 1'b0; #1;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    for (int i = 4; i < DIM_C; i++) begin
      chk_beat("ovr_drain", i, 400 + i);
      tick(); #1;
    end
    chk_idle("ovr_done");
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    set_sums(500); start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    tick(); #1;
    out_ready = 1'b0; start = 1'b1; err_clr = 1'b1; #1;
    chk("ovr_both_clear", {31'd0, acc_clear}, 32'd0);
    tick(); start = 1'b0; err_clr = 1'b0; #1;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    chk_beat("ovr_hold", 1, 501);
    out_ready = 1'b1; #1;
    for (int i = 1; i < DIM_C; i++) begin
      tick(); #1;
    end
    chk_idle("ovr2_done");

    // Max values on every lane.
    for (int i = 0; i < DIM_C; i++) sum_in[i] = '1;
    start = 1'b1; #1;
    tick(); start = 1'b0; set_sums(0); #1;
    for (int i = 0; i < DIM_C; i++) begin
      chk_beat("max", i, 32'hFFFFFF);
      tick(); #1;
    end
    chk_idle("max_done");

    // Reset mid-stream at out_idx 5 (overrun still set from above).
    set_sums(600); start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
    end
    chk_beat("mrst_pre", 5, 605);
    chk("mrst_ovr_pre", {31'd0, overrun}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_idx", {29'd0, out_idx}, 32'd0);
    chk("mrst_ovr", {31'd0, overrun}, 32'd0);
    chk("mrst_data", {8'd0, out_data}, 32'd0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk_idle("mrst_after");
    set_sums(700); start = 1'b1; #1;
    tick(); start = 1'b0; #1;
    for (int i = 0; i < DIM_C; i++) begin
      chk_beat("mrst_fresh", i, 700 + i);
      tick(); #1;
    end
    chk_idle("mrst_fresh_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
